sisc_mc_ctrl: RTL and testbench

Multicycle control unit for the SISC CPU, the next generation of the fixed-latency control FSM. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and adds a variable-latency memory handshake with a parametrised timeout. It also adds load/store/swap control and architectural HALT and FAULT states instead of simulator stops. It sits between the IR/status register and the datapath muxes, register file, PC and memory port.

---
 rtl/sisc_pkg.sv | 42 ++++
 rtl/sisc_wait_timer.sv | 32 +++
 rtl/sisc_mc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sisc_mc_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// sisc_pkg : shared opcode, addressing-mode, ALU-control and state encodings
// Revision : 1.0
// ============================================================================
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [3:0] AM_IMM  = 4'd8;

  localparam logic [1:0] ALU_REG_CC   = 2'b00;
  localparam logic [1:0] ALU_IMM_CC   = 2'b01;
  localparam logic [1:0] ALU_REG_HOLD = 2'b10;
  localparam logic [1:0] ALU_IMM_HOLD = 2'b11;

  typedef enum logic [3:0] {
    ST_START0  = 4'd0,
    ST_START1  = 4'd1,
    ST_FETCH   = 4'd2,
    ST_FETCH_W = 4'd3,
    ST_DECODE  = 4'd4,
    ST_EXECUTE = 4'd5,
    ST_MEM     = 4'd6,
    ST_MEM_W   = 4'd7,
    ST_WB      = 4'd8,
    ST_WB2     = 4'd9,
    ST_HALT    = 4'd10,
    ST_FAULT   = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sisc_wait_timer.sv
`default_nettype none
// ============================================================================
// sisc_wait_timer : memory wait-cycle counter with clear and timeout flag
// Revision : 1.0
// ============================================================================
module sisc_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT));

  // Saturates at TIMEOUT; the FSM leaves the wait state on that cycle anyway.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !expired)
      count <= count + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: rtl/sisc_mc_ctrl.sv
`default_nettype none
// ============================================================================
// sisc_mc_ctrl : SISC multicycle control FSM with variable-latency memory
//                handshake, load/store/swap sequencing and HALT/FAULT states
// Revision : 1.0
// ============================================================================
module sisc_mc_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_f,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  input  logic       mem_rdy,
  output logic       rf_we,
  output logic [1:0] alu_op,
  output logic       wb_sel,
  output logic       br_sel,
  output logic       pc_rst,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       ir_load,
  output logic       rb_sel,
  output logic       mm_sel,
  output logic       mem_req,
  output logic       dm_we,
  output logic       swp_sel,
  output logic       halted,
  output logic       fault
);

  import sisc_pkg::*;

  state_t state, next_state;
  logic   expired;
  logic   is_mem_op;
  logic   br_taken;

  assign is_mem_op = (opcode == OP_LOD) || (opcode == OP_STR) || (opcode == OP_SWP);

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: br_taken = |(mm & stat);
      OP_BNE, OP_BNR: br_taken = ~|(mm & stat);
      default:        br_taken = 1'b0;
    endcase
  end

  // Counter runs only while a request is outstanding and unanswered.
  sisc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_f   (rst_f),
    .clr     (!mem_req || mem_rdy),
    .inc     (mem_req && !mem_rdy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      state <= ST_START1;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    rf_we      = 1'b0;
    alu_op     = ALU_REG_HOLD;
    wb_sel     = 1'b0;
    br_sel     = 1'b0;
    pc_rst     = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    ir_load    = 1'b0;
    rb_sel     = 1'b0;
    mm_sel     = 1'b0;
    mem_req    = 1'b0;
    dm_we      = 1'b0;
    swp_sel    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    case (state)
      ST_START0: next_state = ST_START1;
      ST_START1: begin
        pc_rst     = 1'b1;
        next_state = ST_FETCH;
      end
      ST_FETCH, ST_FETCH_W: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          pc_write   = 1'b1;
          ir_load    = 1'b1;
          next_state = ST_DECODE;
        end else begin
          next_state = expired ? ST_FAULT : ST_FETCH_W;
        end
      end
      ST_DECODE: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
        end
        next_state = (opcode == OP_HLT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (opcode == OP_ALU) begin
          alu_op = (mm == AM_IMM) ? ALU_IMM_CC : ALU_REG_CC;
        end else if (is_mem_op) begin
          alu_op = ALU_IMM_HOLD;
          rb_sel = (opcode != OP_LOD);
        end
        next_state = ST_MEM;
      end
      ST_MEM, ST_MEM_W: begin
        next_state = ST_WB;
        if (opcode == OP_ALU) begin
          alu_op = (mm == AM_IMM) ? ALU_IMM_HOLD : ALU_REG_HOLD;
        end else if (is_mem_op) begin
          alu_op  = ALU_IMM_HOLD;
          mm_sel  = 1'b1;
          mem_req = 1'b1;
          dm_we   = (opcode != OP_LOD);
          if (!mem_rdy)
            next_state = expired ? ST_FAULT : ST_MEM_W;
        end
      end
      ST_WB: begin
        next_state = ST_FETCH;
        case (opcode)
          OP_ALU: rf_we = 1'b1;
          OP_LOD: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          OP_SWP: begin
            rf_we      = 1'b1;
            wb_sel     = 1'b1;
            next_state = ST_WB2;
          end
          default: rf_we = 1'b0;
        endcase
      end
      ST_WB2: begin
        rf_we      = 1'b1;
        swp_sel    = 1'b1;
        next_state = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  next_state = ST_FAULT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sisc_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sisc_mc_ctrl : scoreboard bench for the SISC multicycle control unit
// Revision : 1.0
// ============================================================================
module tb_sisc_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       mem_rdy;
  logic       rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
  logic       rb_sel, mm_sel, mem_req, dm_we, swp_sel, halted, fault;
  logic [1:0] alu_op;
  logic [15:0] obs;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  // Observed-output vector layout (bit positions)
  localparam logic [15:0] RFWE  = 16'h8000;
  localparam logic [15:0] A00   = 16'h0000;
  localparam logic [15:0] A01   = 16'h2000;
  localparam logic [15:0] A10   = 16'h4000;
  localparam logic [15:0] A11   = 16'h6000;
  localparam logic [15:0] WBS   = 16'h1000;
  localparam logic [15:0] BRS   = 16'h0800;
  localparam logic [15:0] PCR   = 16'h0400;
  localparam logic [15:0] PCW   = 16'h0200;
  localparam logic [15:0] PCS   = 16'h0100;
  localparam logic [15:0] IRL   = 16'h0080;
  localparam logic [15:0] RBS   = 16'h0040;
  localparam logic [15:0] MMS   = 16'h0020;
  localparam logic [15:0] MREQ  = 16'h0010;
  localparam logic [15:0] DMWE  = 16'h0008;
  localparam logic [15:0] SWPS  = 16'h0004;
  localparam logic [15:0] HLTD  = 16'h0002;
  localparam logic [15:0] FLT   = 16'h0001;

  localparam logic [15:0] V_S1    = A10 | PCR;
  localparam logic [15:0] V_FOK   = A10 | MREQ | PCW | IRL;
  localparam logic [15:0] V_FW    = A10 | MREQ;
  localparam logic [15:0] V_IDLE  = A10;
  localparam logic [15:0] V_LM    = A11 | MMS | MREQ;
  localparam logic [15:0] V_SM    = A11 | MMS | MREQ | DMWE;
  localparam logic [15:0] V_HALT  = A10 | HLTD;
  localparam logic [15:0] V_FAULT = A10 | FLT;

  sisc_mc_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .mem_rdy  (mem_rdy),
    .rf_we    (rf_we),
    .alu_op   (alu_op),
    .wb_sel   (wb_sel),
    .br_sel   (br_sel),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .ir_load  (ir_load),
    .rb_sel   (rb_sel),
    .mm_sel   (mm_sel),
    .mem_req  (mem_req),
    .dm_we    (dm_we),
    .swp_sel  (swp_sel),
    .halted   (halted),
    .fault    (fault)
  );

  assign obs = {rf_we, alu_op, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
                rb_sel, mm_sel, mem_req, dm_we, swp_sel, halted, fault};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs and queue what that cycle must show.
  task automatic step(input logic rdy, input logic [15:0] e, input string tag);
    mem_rdy = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [15:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {16'd0, obs}, {16'd0, e});
    end
  end

  task automatic async_reset(input string tag);
    rst_f = 1'b0;
    #1;
    check_eq(tag, {16'd0, obs}, {16'd0, V_S1});
    step(1'b0, V_S1, {tag, "_hold"});
    rst_f = 1'b1;
    step(1'b1, V_S1, {tag, "_rel"});
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
    opcode = op;
    mm     = m;
    stat   = s;
  endtask

  initial begin
    rst_f   = 1'b0;
    mem_rdy = 1'b0;
    set_instr(4'd0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    step(1'b0, V_S1, "rst_hold");
    rst_f = 1'b1;
    step(1'b1, V_S1, "rst_release");

    set_instr(4'd8, 4'd0, 4'd0);
    step(1'b1, V_FOK,       "add_fetch");
    step(1'b1, V_IDLE,      "add_dec");
    step(1'b1, A00,         "add_ex");
    step(1'b1, A10,         "add_mem");
    step(1'b1, A10 | RFWE,  "add_wb");

    set_instr(4'd8, 4'd8, 4'd0);
    step(1'b1, V_FOK,       "addi_fetch");
    step(1'b1, V_IDLE,      "addi_dec");
    step(1'b1, A01,         "addi_ex");
    step(1'b1, A11,         "addi_mem");
    step(1'b1, A10 | RFWE,  "addi_wb");

    set_instr(4'd4, 4'b0100, 4'b0100);
    step(1'b1, V_FOK,                   "bra_t_fetch");
    step(1'b1, A10 | PCW | PCS | BRS,   "bra_t_dec");
    for (int i = 0; i < 3; i++) step(1'b1, V_IDLE, "bra_t_tail");

    set_instr(4'd4, 4'b0100, 4'b0000);
    step(1'b1, V_FOK,  "bra_nt_fetch");
    step(1'b1, V_IDLE, "bra_nt_dec");
    for (int i = 0; i < 3; i++) step(1'b1, V_IDLE, "bra_nt_tail");

    set_instr(4'd7, 4'b0100, 4'b0000);
    step(1'b1, V_FOK,             "bnr_fetch");
    step(1'b1, A10 | PCW | PCS,   "bnr_dec");
    for (int i = 0; i < 3; i++) step(1'b1, V_IDLE, "bnr_tail");

    set_instr(4'd1, 4'd0, 4'd0);
    step(1'b1, V_FOK,             "lod_fetch");
    step(1'b1, V_IDLE,            "lod_dec");
    step(1'b1, A11,               "lod_ex");
    step(1'b0, V_LM,              "lod_mem");
    step(1'b0, V_LM,              "lod_mw1");
    step(1'b0, V_LM,              "lod_mw2");
    step(1'b1, V_LM,              "lod_mw3");
    step(1'b1, A10 | RFWE | WBS,  "lod_wb");

    set_instr(4'd2, 4'd0, 4'd0);
    step(1'b1, V_FOK,      "str_fetch");
    step(1'b1, V_IDLE,     "str_dec");
    step(1'b1, A11 | RBS,  "str_ex");
    step(1'b1, V_SM,       "str_mem");
    step(1'b1, V_IDLE,     "str_wb");

    set_instr(4'd3, 4'd0, 4'd0);
    step(1'b1, V_FOK,             "swp_fetch");
    step(1'b1, V_IDLE,            "swp_dec");
    step(1'b1, A11 | RBS,         "swp_ex");
    step(1'b1, V_SM,              "swp_mem");
    step(1'b1, A10 | RFWE | WBS,  "swp_wb");
    step(1'b1, A10 | RFWE | SWPS, "swp_wb2");

    set_instr(4'd11, 4'd0, 4'd0);
    step(1'b1, V_FOK, "undef_fetch");
    for (int i = 0; i < 4; i++) step(1'b1, V_IDLE, "undef_path");

    set_instr(4'd0, 4'd0, 4'd0);
    step(1'b0, V_FW,  "fw_req");
    step(1'b0, V_FW,  "fw_w1");
    step(1'b0, V_FW,  "fw_w2");
    step(1'b1, V_FOK, "fw_done");
    for (int i = 0; i < 4; i++) step(1'b1, V_IDLE, "fw_noop");

    set_instr(4'd15, 4'd0, 4'd0);
    step(1'b1, V_FOK,  "hlt_fetch");
    step(1'b1, V_IDLE, "hlt_dec");
    for (int i = 0; i < 3; i++) step(1'b1, V_HALT, "hlt_sticky");
    async_reset("hlt_rst");

    set_instr(4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) step(1'b0, V_FW, "to_wait");
    step(1'b0, V_FAULT, "to_fault");
    step(1'b0, V_FAULT, "to_fault_hold");
    step(1'b1, V_FAULT, "to_fault_rdy");
    async_reset("fault_rst");

    set_instr(4'd1, 4'd0, 4'd0);
    step(1'b1, V_FOK,  "lr_fetch");
    step(1'b1, V_IDLE, "lr_dec");
    step(1'b1, A11,    "lr_ex");
    step(1'b0, V_LM,   "lr_mem");
    step(1'b0, V_LM,   "lr_mw1");
    async_reset("memw_rst");

    // Three further waits would time out if the count had survived reset.
    set_instr(4'd0, 4'd0, 4'd0);
    step(1'b0, V_FW,  "clr_req");
    step(1'b0, V_FW,  "clr_w1");
    step(1'b0, V_FW,  "clr_w2");
    step(1'b1, V_FOK, "clr_done");
    step(1'b1, V_IDLE, "clr_dec");

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
